// File: rtl/n_sipo_rx.sv
// n_sipo_rx: serial-to-parallel receiver for the N-bit serial shift link.
// Collects N serial bits (MSB first) into a word and presents it through a
// one-word holding buffer with a valid/ready handshake. A sticky flag
// reports completed words dropped because the consumer stalled.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   si         in   serial data bit
//   si_en      in   bit strobe, si sampled when 1
//   flush      in   synchronous discard of the partial word
//   dout       out  [N-1:0] received word, stable while dout_valid=1
//   dout_valid out  dout holds an unconsumed word
//   dout_ready in   consumer accepts the word when dout_valid=1
//   ovf        out  sticky overflow flag
//   ovf_clr    in   synchronous clear of ovf
//   busy       out  partial word in progress (combinational)
module n_sipo_rx #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         si,
  input  logic         si_en,
  input  logic         flush,
  output logic [N-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         ovf,
  input  logic         ovf_clr,
  output logic         busy
);

  localparam int unsigned CW = $clog2(N);

  logic [N-1:0]  sr;
  logic [CW-1:0] cnt;
  logic [N-1:0]  word;
  logic          sample;
  logic          complete;
  logic          load;
  logic          drop;
  logic          drain;

  always_comb begin
    word     = {sr[N-2:0], si};
    sample   = si_en & ~flush;
    complete = sample & (cnt == CW'(N - 1));
    drain    = dout_valid & dout_ready;
    // A completion may load when the buffer is empty or empties on this edge.
    load     = complete & (~dout_valid | dout_ready);
    drop     = complete & dout_valid & ~dout_ready;
  end

  assign busy = (cnt != '0);

  // Bit collection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (flush) begin
      sr  <= '0;
      cnt <= '0;
    end else if (si_en) begin
      sr  <= word;
      cnt <= complete ? '0 : cnt + CW'(1);
    end
  end

  // Holding buffer and handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (load) begin
      dout       <= word;
      dout_valid <= 1'b1;
    end else if (drain) begin
      dout_valid <= 1'b0;
    end
  end

  // Overflow flag: a drop on the same edge as a clear wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: doc/n_sipo_rx.md
# n_sipo_rx

Serial-to-parallel receiver for the N-bit serial shift link. It is the receiving end of the single-bit serial stream driven by the N-stage shift-register transmitter path. It collects N serial bits, MSB first, into a word and presents the word on a parallel output with a valid/ready handshake. A one-word holding buffer decouples bit collection from the consumer, and a sticky flag reports words dropped because the consumer stalled.

## Interface
- N, default 4: word width in bits and number of serial bits per word; legal range 2..32.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- si  input  1  serial data bit.
- si_en  input  1  bit strobe; si is sampled on a rising edge only when si_en=1.
- flush  input  1  synchronous; discards the partial word and restarts the bit count.
- dout  output  N  received word, held stable while dout_valid=1.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts the word on the edge where dout_valid=1 and dout_ready=1.
- ovf  output  1  sticky overflow flag; set when a completed word is dropped.
- ovf_clr  input  1  synchronous clear of ovf.
- busy  output  1  a partial word is in progress (bit count is not 0).

## Operation
- Internal state:
  - sr[N-1:0]: shift register.
  - cnt: bit counter, 0..N-1, width $clog2(N).
  - hold register driving dout.
  - dout_valid flag.
  - ovf flag.
- Shift: on an edge with si_en=1 and flush=0, sr <= {sr[N-2:0], si} and cnt increments. The first bit received ends up in dout[N-1].
- Completion: the edge where si_en=1 and cnt==N-1. The completed word is {sr[N-2:0], si}, and cnt wraps to 0.
- Load rule at completion:
  - Buffer free (dout_valid=0), or buffer draining on this same edge (dout_valid=1 and dout_ready=1): dout <= completed word, and dout_valid is 1 after the edge.
  - Otherwise: the word is dropped, dout and dout_valid are unchanged, and ovf <= 1.
- Handshake:
  - dout_valid=1 and dout_ready=1 with no completion on that edge: dout_valid <= 0 and dout keeps its value.
  - dout_ready is ignored while dout_valid=0.
- flush=1:
  - cnt <= 0 and sr <= 0.
  - Any si_en on that edge is ignored.
  - The hold register, dout_valid and ovf are unaffected.
  - The handshake still operates on that edge.
- ovf_clr=1: ovf <= 0. If a drop occurs on the same edge, the set wins and ovf=1.
- busy = (cnt != 0), combinational from cnt.
- si_en=0: no change to sr or cnt. Idle gaps of any length are allowed between bits.

## Timing
- Reset (rst=0, asynchronous):
  - dout=0, dout_valid=0, ovf=0, busy=0.
  - sr and cnt cleared.
  - Takes effect immediately, without waiting for a clock edge.
- Reset release: the first edge with rst=1 may sample a bit.
- Reset mid-word: the partial word is lost and counting restarts at bit 0.
- Latency: dout and dout_valid update on the same edge that samples bit N. A consumer can take the word on the next edge.
- Throughput: one bit per cycle. With dout_ready held high, one word every N cycles is sustained with no drops. At full rate a word may sit in the buffer for at most N-1 cycles before the next completion.
- Back-to-back completion with a same-edge drain is not an overflow.
- All outputs are registered except busy.

## Test plan
- Basic word, N=4: after reset, drive si_en=1 with si = 0,1,1,0 on four consecutive edges and dout_ready=0.
  - After the 4th edge: dout=4'b0110, dout_valid=1, busy=0, ovf=0.
  - Raising dout_ready for one edge gives dout_valid=0.
- Streaming: dout_ready=1 constantly; send words 4'hA, 4'h5, 4'hF back to back (12 consecutive bits).
  - dout_valid pulses one cycle per word, with dout equal to A, 5 and F in turn.
  - ovf stays 0.
- Overflow: dout_ready=0; send 4'h3 then 4'hC.
  - dout remains 4'h3 with dout_valid=1, and ovf=1 after the 8th bit.
  - ovf_clr for one edge gives ovf=0 while dout is still 4'h3.
- Gapped bits and same-edge drain: send 4'h9 with si_en gaps of 3 idle cycles between bits.
  - Result is dout=4'h9.
  - Then send 4'h6 and assert dout_ready exactly on the edge sampling its last bit: dout=4'h6, dout_valid=1, ovf=0.
- Flush and reset mid-word:
  - Send bits 1,1 then pulse flush; next, send 0,0,1,0. Result is dout=4'h2.
  - Send bits 1,0,1, assert rst=0 mid-cycle: all outputs are 0 immediately.
  - After release, send 4'h7: result is dout=4'h7.
